// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem over req/ack, returns words in order via a 2-entry buffer.
// Ack in cycle N is on instr in N+1; stall holds the head, and a request only issues when its reply has a slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  entry_t      r_head;
  entry_t      r_skid;
  entry_t      w_new;
  logic        r_head_vld;
  logic        r_skid_vld;
  logic [1:0]  w_occ;
  logic [1:0]  w_occ_nxt;
  logic        w_pop;
  logic        w_push;
  logic        w_room;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_occ      = {1'b0, r_head_vld} + {1'b0, r_skid_vld};
  assign w_pop      = r_head_vld & ~stall & ~redirect;
  assign w_push     = imem_req & imem_ack & (r_state == S_WAIT) & ~redirect;
  assign w_occ_nxt  = w_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_room     = (w_occ_nxt <= 2'd1);
  assign w_new      = '{dat: imem_rdata, pc: r_pc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An unacked request at redirect time must still complete, so its reply is drained and dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect || w_room) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_nxt = imem_ack ? S_WAIT : S_DRAIN;
        end else if (imem_ack && !w_room) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_ack) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req      = (r_state != S_IDLE);
    imem_addr     = (r_state == S_DRAIN) ? r_addr : r_pc;
    instr_valid   = r_head_vld;
    instr         = r_head_vld ? r_head.dat : 32'h0;
    op            = r_head_vld ? r_head.dat[31:26] : 6'h0;
    instr_pc      = r_head_vld ? r_head.pc : 32'h0;
    instr_pcplus4 = r_head_vld ? (r_head.pc + 32'd4) : 32'h0;
  end

  // r_addr remembers the address on the bus so DRAIN can keep it stable after pc moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      if (r_state == S_WAIT) r_addr <= r_pc;
      if (redirect) begin
        r_pc <= w_redir_pc;
      end else if (w_push) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (redirect) begin
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_head     <= r_skid;
          r_head_vld <= r_skid_vld;
          r_skid_vld <= 1'b0;
        end
        2'b10: begin
          if (!r_head_vld) begin
            r_head     <= w_new;
            r_head_vld <= 1'b1;
          end else begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
          end
        end
        2'b11: begin
          if (r_skid_vld) begin
            r_head <= r_skid;
            r_skid <= w_new;
          end else begin
            r_head <= w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized stall/redirect/latency
// traffic checked every cycle against a transaction-level model (queue of fetched words, expected fetch stream).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  int errors = 0;
  int checks = 0;
  int mem_lat_mode = 0;
  int npop = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .op(op),
    .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h8C08_0004;
      32'h0040_0004: return 32'hAC08_0008;
      32'h0040_0008: return 32'h2009_0001;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: fixed latency (mem_lat_mode >= 0) or random 0..3 cycles per request.
  initial begin
    logic rp, ap;
    int waited, lat;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    waited = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      rp = imem_req;
      ap = imem_ack;
      @(posedge clk);
      #1;
      if (rp && !ap && imem_req) begin
        waited++;
      end else begin
        waited = 0;
        lat = (mem_lat_mode < 0) ? int'($urandom_range(0, 3)) : mem_lat_mode;
      end
      imem_ack = imem_req && (waited >= lat);
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
    end
  end

  // Reference model: buffered words in order, the address the next useful fetch must use,
  // and whether the outstanding request was overtaken by a redirect.
  logic [31:0] m_dat[$];
  logic [31:0] m_pc[$];
  logic [31:0] m_fetch = RST_PC;
  bit          m_stale = 1'b0;
  bit          p_pend = 1'b0;
  logic [31:0] p_addr = 32'h0;

  always @(negedge clk) begin
    bit pop, hs;
    if (!reset_n) begin
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pcplus4", instr_pcplus4, 32'h0);
      m_dat.delete();
      m_pc.delete();
      m_fetch = RST_PC;
      m_stale = 1'b0;
      p_pend = 1'b0;
    end else begin
      chk("valid", 32'(instr_valid), 32'(m_dat.size() > 0));
      if (m_dat.size() > 0) begin
        chk("instr", instr, m_dat[0]);
        chk("op", 32'(op), 32'(m_dat[0] >> 26));
        chk("instr_pc", instr_pc, m_pc[0]);
        chk("pcplus4", instr_pcplus4, m_pc[0] + 32'd4);
      end else begin
        chk("idle_instr", instr, 32'h0);
        chk("idle_op", 32'(op), 32'h0);
        chk("idle_pc", instr_pc, 32'h0);
      end
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (p_pend) begin
        chk("req_hold", 32'(imem_req), 32'h1);
        chk("addr_hold", imem_addr, p_addr);
      end
      pop = (m_dat.size() > 0) && !stall && !redirect;
      hs  = imem_req && imem_ack;
      if (redirect) begin
        m_dat.delete();
        m_pc.delete();
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
        m_stale = imem_req && !imem_ack;
      end else begin
        if (pop) begin
          void'(m_dat.pop_front());
          void'(m_pc.pop_front());
          npop++;
        end
        if (hs) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            chk("fetch_addr", imem_addr, m_fetch);
            m_dat.push_back(imem_rdata);
            m_pc.push_back(imem_addr);
            m_fetch = m_fetch + 32'd4;
            chk("occupancy_le2", 32'(m_dat.size() <= 2), 32'h1);
          end
        end
      end
      p_pend = imem_req && !imem_ack;
      p_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    mem_lat_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("t0_req", 32'(imem_req), 32'h0);
    chk("t0_valid", 32'(instr_valid), 32'h0);
    chk("t0_op", 32'(op), 32'h0);

    // 1: zero-wait stream after reset release
    reset_n = 1'b1;
    chk("t1_req_idle", 32'(imem_req), 32'h0);
    tick();
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr0", imem_addr, 32'h0040_0000);
    chk("t1_valid0", 32'(instr_valid), 32'h0);
    tick();
    chk("t1_addr1", imem_addr, 32'h0040_0004);
    chk("t1_instr0", instr, 32'h8C08_0004);
    chk("t1_op0", 32'(op), 32'h23);
    chk("t1_pc0", instr_pc, 32'h0040_0000);
    chk("t1_pc4_0", instr_pcplus4, 32'h0040_0004);
    tick();
    chk("t1_addr2", imem_addr, 32'h0040_0008);
    chk("t1_instr1", instr, 32'hAC08_0008);
    chk("t1_op1", 32'(op), 32'h2B);
    tick();
    chk("t1_valid2", 32'(instr_valid), 32'h1);
    chk("t1_instr2", instr, 32'h2009_0001);
    chk("t1_op2", 32'(op), 32'h08);
    chk("t1_pc2", instr_pc, 32'h0040_0008);

    // 2: stall three cycles with the first word at the head
    do_reset();
    tick();
    tick();
    chk("t2_head", instr, 32'h8C08_0004);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_instr", instr, 32'h8C08_0004);
      chk("t2_hold_pc", instr_pc, 32'h0040_0000);
      chk("t2_req_low", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("t2_next1", instr, 32'hAC08_0008);
    chk("t2_req_back", 32'(imem_req), 32'h1);
    chk("t2_addr_back", imem_addr, 32'h0040_0008);
    tick();
    chk("t2_next2", instr, 32'h2009_0001);
    tick();
    chk("t2_next3_pc", instr_pc, 32'h0040_000C);

    // 3: redirect during a slow request
    mem_lat_mode = 3;
    do_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0040_0103;
    tick();
    redirect = 1'b0;
    chk("t3_drain_req", 32'(imem_req), 32'h1);
    n = 0;
    while (!(imem_req && imem_addr == 32'h0040_0100) && n < 12) begin
      chk("t3_old_addr", imem_addr, 32'h0040_0000);
      chk("t3_valid_low", 32'(instr_valid), 32'h0);
      tick();
      n++;
    end
    chk("t3_new_req_seen", 32'(n < 12), 32'h1);
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    chk("t3_valid_seen", 32'(n < 12), 32'h1);
    chk("t3_first_pc", instr_pc, 32'h0040_0100);
    chk("t3_first_instr", instr, mem_word(32'h0040_0100));

    // 4: redirect in the ack cycle
    mem_lat_mode = 0;
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("t4_addr", imem_addr, 32'h0000_0040);
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_valid", 32'(instr_valid), 32'h0);
    tick();
    chk("t4_pc", instr_pc, 32'h0000_0040);

    // 5: PC wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("t5_pcplus4", instr_pcplus4, 32'h0000_0000);
    chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
    tick();
    chk("t5_pc_wrap", instr_pc, 32'h0000_0000);

    // 6: asynchronous reset while a request is outstanding and the buffer is occupied
    mem_lat_mode = 2;
    stall = 1'b1;
    do_reset();
    n = 0;
    while (!(instr_valid && imem_req) && n < 12) begin
      tick();
      n++;
    end
    chk("t6_busy_seen", 32'(n < 12), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_req_drop", 32'(imem_req), 32'h0);
    chk("t6_valid_drop", 32'(instr_valid), 32'h0);
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_restart_addr", imem_addr, RST_PC);
    chk("t6_restart_req", 32'(imem_req), 32'h1);

    // Random traffic
    mem_lat_mode = -1;
    npop = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = $urandom();
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = RST_PC + 32'($urandom_range(0, 255));
      endcase
      tick();
    end
    stall = 1'b0;
    redirect = 1'b0;
    repeat (5) tick();
    chk("liveness_pops", 32'(npop > 300), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
